regfile_multiport: RTL and testbench
====================================

REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; depth = 2**ADDR_W registers.
REQ-003 SHALL have parameter NUM_RD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-005 SHALL have parameter REG_OUT, default 0, 0 = combinational read data, 1 = read data registered (1-cycle latency).
REQ-006 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-008 SHALL have port rd_addr  input  NUM_RD*ADDR_W  packed read addresses, port i at bits [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port rd_data  output  NUM_RD*DATA_W  packed read data, same packing.
REQ-010 SHALL have port rd_pending  output  NUM_RD  per-port flag: addressed register awaits a reserved write.
REQ-011 SHALL have port we  input  1  write enable.
REQ-012 SHALL have port wr_addr  input  ADDR_W  write address.
REQ-013 SHALL have port wr_data  input  DATA_W  write data.
REQ-014 SHALL have port rsv_en  input  1  reserve request: mark rsv_addr as pending.
REQ-015 SHALL have port rsv_addr  input  ADDR_W  register to reserve.

Function
REQ-016 Register 0 SHALL read as zero always; writes and reservations to address 0 SHALL be ignored.
REQ-017 When we=1 and wr_addr!=0, reg[wr_addr] SHALL take wr_data at the rising edge.
REQ-018 REG_OUT=0: rd_data[i] SHALL equal reg[rd_addr[i]] combinationally.
REQ-019 REG_OUT=1: rd_data[i] SHALL be the value sampled at the rising edge, visible the following cycle.
REQ-020 BYPASS=1: when we=1, wr_addr==rd_addr[i]!=0, the value presented/captured for port i SHALL be wr_data; BYPASS=0: the old value.
REQ-021 Pending bit p[a] SHALL set at the edge where rsv_en=1, rsv_addr=a!=0.
REQ-022 Pending bit p[a] SHALL clear at the edge where we=1, wr_addr=a, unless rsv_en=1 with rsv_addr=a in the same cycle, in which case p[a] SHALL remain set (new producer wins).
REQ-023 Reserving an already-pending register SHALL leave it pending; a write to a non-pending register SHALL not alter any pending bit.
REQ-024 rd_pending[i] SHALL equal p[rd_addr[i]], with the same latency as rd_data[i]; with BYPASS=1 a clearing write to that address in the current cycle SHALL yield 0.
REQ-025 Multiple read ports addressing the same register SHALL all return identical data and pending.

Reset
REQ-026 rst_n low SHALL immediately clear all registers, all pending bits and (REG_OUT=1) rd_data/rd_pending to zero, independent of clk.
REQ-027 Writes and reservations during reset SHALL be discarded; operation resumes at first rising edge after rst_n deasserts.
REQ-028 Reset asserted mid-sequence SHALL lose all pending reservations; no partial state survives.

Structure
REQ-029 Shared package SHALL hold default DATA_W/ADDR_W constants and the REG_ZERO address constant, shared with the datapath and control unit.
REQ-030 One sub-module regfile_rd_port (address decode, bypass mux, optional output register) SHALL be instantiated NUM_RD times via generate.

Verification
REQ-031 Write 15 to r1 at we=1, read port 0 addr 1 -> 15 (REG_OUT=0 same cycle after edge; REG_OUT=1 one cycle later).
REQ-032 Write 0xDEADBEEF to r0, read r0 on all ports -> 0; rsv r0 -> rd_pending 0.
REQ-033 BYPASS=1: we=1 r5<=0xA5A5A5A5 while rd_addr[1]=5 same cycle -> rd_data[1]=0xA5A5A5A5; BYPASS=0 -> old value.
REQ-034 rsv r7, next cycle rd_pending for r7 =1; write r7=9 -> pending 0, data 9; same-cycle rsv r7 + write r7 -> pending stays 1.
REQ-035 Fill r1..r31 with index values, assert rst_n=0 between edges -> all reads 0 and all pending 0 immediately.
REQ-036 Sweep DATA_W=16/ADDR_W=3/NUM_RD=4 and REG_OUT=1: rerun REQ-031..035 with width-scaled values, all ports identical results.

Source files
------------

// File: rtl/regfile_multiport_pkg.sv
// Shared constants for the multi-port register file: default geometry and the
// hard-wired zero register address.
package regfile_multiport_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int REG_ZERO   = 0;

    // True when an address refers to the hard-wired zero register.
    function automatic logic is_reg_zero(input logic [31:0] addr);
        return addr == 32'(REG_ZERO);
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One read port: register/pending select, same-cycle write forwarding and an
// optional output register stage.
module regfile_rd_port
    import regfile_multiport_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int BYPASS  = 1,
    parameter int REG_OUT = 0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [ADDR_W-1:0]                    rd_addr_i,
    input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]   mem_i,
    input  logic [(1<<ADDR_W)-1:0]               pend_i,
    input  logic                                 wr_fwd_i,
    input  logic                                 wr_clr_i,
    input  logic [ADDR_W-1:0]                    wr_addr_i,
    input  logic [DATA_W-1:0]                    wr_data_i,
    output logic [DATA_W-1:0]                    rd_data_o,
    output logic                                 rd_pending_o
);

    logic [DATA_W-1:0] sel_data;
    logic              sel_pend;
    logic              fwd_hit;
    logic [DATA_W-1:0] data_q;
    logic              pend_q;

    // wr_fwd_i is already qualified against the zero register, so a hit never
    // forwards onto address 0.
    always_comb begin
        fwd_hit  = (BYPASS != 0) && wr_fwd_i && (wr_addr_i == rd_addr_i);
        sel_data = mem_i[rd_addr_i];
        sel_pend = pend_i[rd_addr_i];
        if (fwd_hit) begin
            sel_data = wr_data_i;
            sel_pend = sel_pend && !wr_clr_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            pend_q <= 1'b0;
        end else begin
            data_q <= sel_data;
            pend_q <= sel_pend;
        end
    end

    // With REG_OUT=0 the capture flops are left unloaded and trimmed away.
    assign rd_data_o    = (REG_OUT != 0) ? data_q : sel_data;
    assign rd_pending_o = (REG_OUT != 0) ? pend_q : sel_pend;

endmodule

// File: rtl/regfile_multiport.sv
// Multi-port register file with a zero register, per-register pending
// (scoreboard) bits set by reservations and cleared by writes.
module regfile_multiport
    import regfile_multiport_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int NUM_RD  = 2,
    parameter int BYPASS  = 1,
    parameter int REG_OUT = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_pending,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
    logic [DEPTH-1:0]             pend_q, pend_d;
    logic                         wr_ok;
    logic                         rsv_ok;
    logic                         wr_clr;

    assign wr_ok  = we && !is_reg_zero(32'(wr_addr));
    assign rsv_ok = rsv_en && !is_reg_zero(32'(rsv_addr));
    // A write only retires the pending bit when no new producer claims it.
    assign wr_clr = wr_ok && !(rsv_ok && (rsv_addr == wr_addr));

    always_comb begin
        mem_d  = mem_q;
        pend_d = pend_q;
        if (wr_ok) begin
            mem_d[wr_addr]  = wr_data;
            pend_d[wr_addr] = 1'b0;
        end
        if (rsv_ok) begin
            pend_d[rsv_addr] = 1'b1;
        end
        mem_d[REG_ZERO]  = '0;
        pend_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q  <= '0;
            pend_q <= '0;
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        regfile_rd_port #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .BYPASS  (BYPASS),
            .REG_OUT (REG_OUT)
        ) u_rd_port (
            .clk          (clk),
            .rst_n        (rst_n),
            .rd_addr_i    (rd_addr[g*ADDR_W +: ADDR_W]),
            .mem_i        (mem_q),
            .pend_i       (pend_q),
            .wr_fwd_i     (wr_ok),
            .wr_clr_i     (wr_clr),
            .wr_addr_i    (wr_addr),
            .wr_data_i    (wr_data),
            .rd_data_o    (rd_data[g*DATA_W +: DATA_W]),
            .rd_pending_o (rd_pending[g])
        );
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: default instance (32b/32 regs/2 ports, forwarding,
// combinational read) and a 16b/8 regs/4 ports instance without forwarding, registered read.
module tb_regfile_multiport;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // instance A: defaults
    logic [9:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_pend;
    logic        a_we, a_rsv;
    logic [4:0]  a_wa, a_ra;
    logic [31:0] a_wd;

    // instance B: DATA_W=16, ADDR_W=3, NUM_RD=4, BYPASS=0, REG_OUT=1
    logic [11:0] b_rd_addr;
    logic [63:0] b_rd_data;
    logic [3:0]  b_rd_pend;
    logic        b_we, b_rsv;
    logic [2:0]  b_wa, b_ra;
    logic [15:0] b_wd;

    regfile_multiport u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_pending(a_rd_pend),
        .we(a_we), .wr_addr(a_wa), .wr_data(a_wd),
        .rsv_en(a_rsv), .rsv_addr(a_ra)
    );

    regfile_multiport #(
        .DATA_W(16), .ADDR_W(3), .NUM_RD(4), .BYPASS(0), .REG_OUT(1)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_pending(b_rd_pend),
        .we(b_we), .wr_addr(b_wa), .wr_data(b_wd),
        .rsv_en(b_rsv), .rsv_addr(b_ra)
    );

    int total = 0;
    int bad   = 0;

    // reference state: register contents and pending flags as plain arrays
    logic [31:0] ma[32];
    logic        pa[32];
    logic [15:0] mb[8];
    logic        pb[8];
    // what instance B will show this cycle (captured at the previous edge)
    logic [15:0] eb_d[4];
    logic        eb_p[4];

    task automatic model_clear();
        for (int k = 0; k < 32; k++) begin ma[k] = '0; pa[k] = 1'b0; end
        for (int k = 0; k < 8; k++)  begin mb[k] = '0; pb[k] = 1'b0; end
        for (int k = 0; k < 4; k++)  begin eb_d[k] = '0; eb_p[k] = 1'b0; end
    endtask

    function automatic logic [31:0] exp_a_d(input int i);
        logic [4:0] ad;
        ad = a_rd_addr[i*5 +: 5];
        if (ad == 0) return 32'h0;
        if (a_we && a_wa == ad) return a_wd;
        return ma[ad];
    endfunction

    function automatic logic exp_a_p(input int i);
        logic [4:0] ad;
        ad = a_rd_addr[i*5 +: 5];
        if (ad == 0) return 1'b0;
        if (a_we && a_wa == ad && !(a_rsv && a_ra == ad)) return 1'b0;
        return pa[ad];
    endfunction

    task automatic idle();
        a_we = 0; a_rsv = 0; a_wa = '0; a_ra = '0; a_wd = '0;
        b_we = 0; b_rsv = 0; b_wa = '0; b_ra = '0; b_wd = '0;
    endtask

    task automatic set_rd_a(input logic [4:0] ad);
        a_rd_addr = {ad, ad};
    endtask

    task automatic set_rd_b(input logic [2:0] ad);
        b_rd_addr = {ad, ad, ad, ad};
    endtask

    // advance one clock edge and apply the register-file rules to the model
    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            logic [2:0] bd;
            bd = b_rd_addr[k*3 +: 3];
            eb_d[k] = mb[bd];
            eb_p[k] = pb[bd];
        end
        if (a_we && a_wa != 0) begin ma[a_wa] = a_wd; pa[a_wa] = 1'b0; end
        if (a_rsv && a_ra != 0) pa[a_ra] = 1'b1;
        if (b_we && b_wa != 0) begin mb[b_wa] = b_wd; pb[b_wa] = 1'b0; end
        if (b_rsv && b_ra != 0) pb[b_ra] = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        set_rd_a(5'd3);
        set_rd_b(3'd3);
        #2;
        total++; if (a_rd_data !== 64'h0) begin bad++; $display("FAIL reset_a_data: got %h want 0", a_rd_data); end
        total++; if (a_rd_pend !== 2'b0)  begin bad++; $display("FAIL reset_a_pend: got %b want 0", a_rd_pend); end
        total++; if (b_rd_data !== 64'h0) begin bad++; $display("FAIL reset_b_data: got %h want 0", b_rd_data); end
        total++; if (b_rd_pend !== 4'b0)  begin bad++; $display("FAIL reset_b_pend: got %b want 0", b_rd_pend); end
        // writes and reservations issued while in reset must be dropped
        a_we = 1; a_wa = 5'd3; a_wd = 32'h1234_5678; a_rsv = 1; a_ra = 5'd3;
        b_we = 1; b_wa = 3'd3; b_wd = 16'h1234;      b_rsv = 1; b_ra = 3'd3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        #1;
        total++; if (a_rd_data[31:0] !== 32'h0) begin bad++; $display("FAIL rst_drop_a_data: got %h want 0", a_rd_data[31:0]); end
        total++; if (a_rd_pend[0] !== 1'b0)     begin bad++; $display("FAIL rst_drop_a_pend: got %b want 0", a_rd_pend[0]); end
        tick();
        @(negedge clk);
        total++; if (b_rd_data[15:0] !== 16'h0) begin bad++; $display("FAIL rst_drop_b_data: got %h want 0", b_rd_data[15:0]); end
        total++; if (b_rd_pend[0] !== 1'b0)     begin bad++; $display("FAIL rst_drop_b_pend: got %b want 0", b_rd_pend[0]); end
        tick();
    endtask

    task automatic test_write_read();
        a_we = 1; a_wa = 5'd1; a_wd = 32'd15; set_rd_a(5'd1);
        b_we = 1; b_wa = 3'd1; b_wd = 16'd15; set_rd_b(3'd1);
        @(negedge clk);
        total++; if (a_rd_data[31:0] !== 32'd15) begin bad++; $display("FAIL wr_rd_a_fwd: got %0d want 15", a_rd_data[31:0]); end
        tick();
        idle();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            total++; if (a_rd_data[i*32 +: 32] !== 32'd15) begin bad++; $display("FAIL wr_rd_a_p%0d: got %0d want 15", i, a_rd_data[i*32 +: 32]); end
        end
        for (int i = 0; i < 4; i++) begin
            total++; if (b_rd_data[i*16 +: 16] !== 16'd0) begin bad++; $display("FAIL wr_rd_b_lat_p%0d: got %0d want 0", i, b_rd_data[i*16 +: 16]); end
        end
        tick();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            total++; if (b_rd_data[i*16 +: 16] !== 16'd15) begin bad++; $display("FAIL wr_rd_b_p%0d: got %0d want 15", i, b_rd_data[i*16 +: 16]); end
        end
        tick();
    endtask

    task automatic test_zero_reg();
        a_we = 1; a_wa = 5'd0; a_wd = 32'hDEAD_BEEF; a_rsv = 1; a_ra = 5'd0; set_rd_a(5'd0);
        b_we = 1; b_wa = 3'd0; b_wd = 16'hBEEF;      b_rsv = 1; b_ra = 3'd0; set_rd_b(3'd0);
        tick();
        idle();
        tick();
        @(negedge clk);
        total++; if (a_rd_data !== 64'h0) begin bad++; $display("FAIL zero_a_data: got %h want 0", a_rd_data); end
        total++; if (a_rd_pend !== 2'b0)  begin bad++; $display("FAIL zero_a_pend: got %b want 0", a_rd_pend); end
        total++; if (b_rd_data !== 64'h0) begin bad++; $display("FAIL zero_b_data: got %h want 0", b_rd_data); end
        total++; if (b_rd_pend !== 4'b0)  begin bad++; $display("FAIL zero_b_pend: got %b want 0", b_rd_pend); end
        tick();
    endtask

    task automatic test_bypass();
        a_we = 1; a_wa = 5'd5; a_wd = 32'hA5A5_A5A5; a_rd_addr = {5'd5, 5'd2};
        b_we = 1; b_wa = 3'd5; b_wd = 16'hA5A5;      b_rd_addr = {3'd2, 3'd2, 3'd5, 3'd2};
        @(negedge clk);
        total++; if (a_rd_data[63:32] !== 32'hA5A5_A5A5) begin bad++; $display("FAIL bypass_a: got %h want a5a5a5a5", a_rd_data[63:32]); end
        tick();
        idle();
        @(negedge clk);
        total++; if (b_rd_data[31:16] !== 16'h0) begin bad++; $display("FAIL nobypass_b_old: got %h want 0", b_rd_data[31:16]); end
        tick();
        @(negedge clk);
        total++; if (b_rd_data[31:16] !== 16'hA5A5) begin bad++; $display("FAIL nobypass_b_new: got %h want a5a5", b_rd_data[31:16]); end
        tick();
    endtask

    task automatic test_pending();
        a_rsv = 1; a_ra = 5'd7; set_rd_a(5'd7);
        b_rsv = 1; b_ra = 3'd7; set_rd_b(3'd7);
        tick();
        idle();
        @(negedge clk);
        total++; if (a_rd_pend !== 2'b11) begin bad++; $display("FAIL pend_set_a: got %b want 11", a_rd_pend); end
        tick();
        @(negedge clk);
        total++; if (b_rd_pend !== 4'hF) begin bad++; $display("FAIL pend_set_b: got %b want 1111", b_rd_pend); end
        a_we = 1; a_wa = 5'd7; a_wd = 32'd9;
        b_we = 1; b_wa = 3'd7; b_wd = 16'd9;
        #1;
        total++; if (a_rd_pend !== 2'b00) begin bad++; $display("FAIL pend_fwd_clr_a: got %b want 00", a_rd_pend); end
        total++; if (a_rd_data[31:0] !== 32'd9) begin bad++; $display("FAIL pend_fwd_data_a: got %0d want 9", a_rd_data[31:0]); end
        tick();
        idle();
        @(negedge clk);
        total++; if (a_rd_pend !== 2'b00) begin bad++; $display("FAIL pend_clr_a: got %b want 00", a_rd_pend); end
        total++; if (b_rd_pend !== 4'hF)  begin bad++; $display("FAIL pend_clr_b_lat: got %b want 1111", b_rd_pend); end
        tick();
        @(negedge clk);
        total++; if (b_rd_pend !== 4'h0) begin bad++; $display("FAIL pend_clr_b: got %b want 0000", b_rd_pend); end
        total++; if (b_rd_data[15:0] !== 16'd9) begin bad++; $display("FAIL pend_data_b: got %0d want 9", b_rd_data[15:0]); end
        a_we = 1; a_wa = 5'd7; a_wd = 32'd3; a_rsv = 1; a_ra = 5'd7;
        b_we = 1; b_wa = 3'd7; b_wd = 16'd3; b_rsv = 1; b_ra = 3'd7;
        tick();
        idle();
        @(negedge clk);
        total++; if (a_rd_pend !== 2'b11) begin bad++; $display("FAIL pend_newprod_a: got %b want 11", a_rd_pend); end
        total++; if (a_rd_data[31:0] !== 32'd3) begin bad++; $display("FAIL pend_newprod_data_a: got %0d want 3", a_rd_data[31:0]); end
        tick();
        @(negedge clk);
        total++; if (b_rd_pend !== 4'hF) begin bad++; $display("FAIL pend_newprod_b: got %b want 1111", b_rd_pend); end
        tick();
    endtask

    task automatic test_random(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            a_we = 1'($urandom_range(0, 1)); a_wa = 5'($urandom); a_wd = $urandom;
            a_rsv = ($urandom_range(0, 3) == 0); a_ra = 5'($urandom);
            a_rd_addr = 10'($urandom);
            b_we = 1'($urandom_range(0, 1)); b_wa = 3'($urandom); b_wd = 16'($urandom);
            b_rsv = ($urandom_range(0, 2) == 0); b_ra = 3'($urandom);
            b_rd_addr = 12'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                set_rd_a(a_wa);
                set_rd_b(b_wa);
            end
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                total++; if (a_rd_data[i*32 +: 32] !== exp_a_d(i)) begin bad++; $display("FAIL rand_a_data c%0d p%0d: got %h want %h", c, i, a_rd_data[i*32 +: 32], exp_a_d(i)); end
                total++; if (a_rd_pend[i] !== exp_a_p(i)) begin bad++; $display("FAIL rand_a_pend c%0d p%0d: got %b want %b", c, i, a_rd_pend[i], exp_a_p(i)); end
            end
            for (int i = 0; i < 4; i++) begin
                total++; if (b_rd_data[i*16 +: 16] !== eb_d[i]) begin bad++; $display("FAIL rand_b_data c%0d p%0d: got %h want %h", c, i, b_rd_data[i*16 +: 16], eb_d[i]); end
                total++; if (b_rd_pend[i] !== eb_p[i]) begin bad++; $display("FAIL rand_b_pend c%0d p%0d: got %b want %b", c, i, b_rd_pend[i], eb_p[i]); end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_reset_mid();
        for (int r = 1; r < 32; r++) begin
            a_we = 1; a_wa = 5'(r); a_wd = 32'(r); a_rsv = 1; a_ra = 5'(32 - r);
            b_we = (r < 8); b_wa = 3'(r); b_wd = 16'(r); b_rsv = (r < 8); b_ra = 3'(8 - r);
            tick();
        end
        idle();
        set_rd_a(5'd9);
        set_rd_b(3'd6);
        tick();
        @(negedge clk);
        total++; if (a_rd_data[31:0] !== 32'd9) begin bad++; $display("FAIL fill_a: got %0d want 9", a_rd_data[31:0]); end
        total++; if (b_rd_data[15:0] !== 16'd6) begin bad++; $display("FAIL fill_b: got %0d want 6", b_rd_data[15:0]); end
        #1;
        rst_n = 1'b0;
        model_clear();
        #1;
        total++; if (b_rd_data !== 64'h0) begin bad++; $display("FAIL midrst_b_data: got %h want 0", b_rd_data); end
        total++; if (b_rd_pend !== 4'h0)  begin bad++; $display("FAIL midrst_b_pend: got %b want 0", b_rd_pend); end
        for (int r = 0; r < 32; r++) begin
            set_rd_a(5'(r));
            #1;
            total++; if (a_rd_data !== 64'h0) begin bad++; $display("FAIL midrst_a_data r%0d: got %h want 0", r, a_rd_data); end
            total++; if (a_rd_pend !== 2'b0)  begin bad++; $display("FAIL midrst_a_pend r%0d: got %b want 0", r, a_rd_pend); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tick();
        test_random(100);
    endtask

    initial begin
        model_clear();
        idle();
        a_rd_addr = '0;
        b_rd_addr = '0;
        test_reset();
        test_write_read();
        test_zero_reg();
        test_bypass();
        test_pending();
        test_random(400);
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
